// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage; the master modport is its surrounding pipeline.
interface decode_stage_if #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32
);
   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_instr;
   logic [PC_WIDTH-1:0] in_pc;
   logic                out_valid;
   logic                out_ready;
   logic [PC_WIDTH-1:0] out_pc;
   logic [4:0]          out_rs1_addr;
   logic [4:0]          out_rs2_addr;
   logic [4:0]          out_rd_addr;
   logic                out_rs1_read;
   logic                out_rs2_read;
   logic                out_rd_write;
   logic [XLEN-1:0]     out_imm;
   logic [4:0]          out_alu_op;
   logic [1:0]          out_src1_sel;
   logic [1:0]          out_src2_sel;
   logic                out_illegal;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
             out_rs1_read, out_rs2_read, out_rd_write, out_imm, out_alu_op,
             out_src1_sel, out_src2_sel, out_illegal
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
             out_rs1_read, out_rs2_read, out_rd_write, out_imm, out_alu_op,
             out_src1_sel, out_src2_sel, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I(+M) decode stage: one pipeline register between fetch and execute,
// with illegal-instruction trap hold and flush.
module decode_stage #(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter bit ENABLE_M = 1'b0
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);

   if (XLEN != 32) begin : g_xlen_check
      $error("decode_stage: XLEN must be 32");
   end

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;
   localparam logic [4:0] ALU_MUL   = 5'd12;
   localparam logic [4:0] ALU_DIV   = 5'd16;

   localparam logic [1:0] SRC1_RS1  = 2'd0;
   localparam logic [1:0] SRC1_PC   = 2'd1;
   localparam logic [1:0] SRC1_ZERO = 2'd2;
   localparam logic [1:0] SRC2_RS2  = 2'd0;
   localparam logic [1:0] SRC2_IMM  = 2'd1;
   localparam logic [1:0] SRC2_FOUR = 2'd2;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_TRAP = 1'b1;

   typedef struct packed {
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
      logic            rs1_read;
      logic            rs2_read;
      logic            rd_write;
      logic [XLEN-1:0] imm;
      logic [4:0]      alu_op;
      logic [1:0]      src1_sel;
      logic [1:0]      src2_sel;
      logic            illegal;
   } bundle_t;

   logic [31:0]         instr;
   logic [6:0]          opcode;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic                illegal;
   bundle_t             dec;
   bundle_t             bundle_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic                valid_q;
   logic [0:0]          state_q;
   logic                xfer;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   // Base integer ALU op selected by funct3; alt picks SUB/SRA where funct7[5] is set.
   function automatic logic [4:0] base_alu(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
         3'b001:  base_alu = ALU_SLL;
         3'b010:  base_alu = ALU_SLT;
         3'b011:  base_alu = ALU_SLTU;
         3'b100:  base_alu = ALU_XOR;
         3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
         3'b110:  base_alu = ALU_OR;
         default: base_alu = ALU_AND;
      endcase
   endfunction

   always_comb begin
      // NOTE: every field gets a default before the case, so no path can infer a latch.
      dec          = '0;
      illegal      = 1'b0;
      dec.rs1_addr = instr[19:15];
      dec.rs2_addr = instr[24:20];
      dec.rd_addr  = instr[11:7];
      case (opcode)
         OPC_OP_IMM: begin
            dec.rs1_read = 1'b1;
            dec.rd_write = 1'b1;
            dec.src2_sel = SRC2_IMM;
            dec.imm      = imm_i;
            dec.alu_op   = base_alu(f3, (f3 == 3'b101) && f7[5]);
            if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
            if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
         end
         OPC_OP: begin
            dec.rs1_read = 1'b1;
            dec.rs2_read = 1'b1;
            dec.rd_write = 1'b1;
            case (f7)
               7'b0000000: dec.alu_op = base_alu(f3, 1'b0);
               7'b0100000: begin
                  dec.alu_op = base_alu(f3, 1'b1);
                  illegal    = (f3 != 3'b000) && (f3 != 3'b101);
               end
               7'b0000001: begin
                  dec.alu_op = f3[2] ? ALU_DIV + {3'b000, f3[1:0]} : ALU_MUL + {3'b000, f3[1:0]};
                  illegal    = !ENABLE_M;
               end
               default: illegal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec.rd_write = 1'b1;
            dec.alu_op   = ALU_PASSB;
            dec.src1_sel = SRC1_ZERO;
            dec.src2_sel = SRC2_IMM;
            dec.imm      = imm_u;
         end
         OPC_AUIPC: begin
            dec.rd_write = 1'b1;
            dec.src1_sel = SRC1_PC;
            dec.src2_sel = SRC2_IMM;
            dec.imm      = imm_u;
         end
         OPC_JAL: begin
            dec.rd_write = 1'b1;
            dec.src1_sel = SRC1_PC;
            dec.src2_sel = SRC2_FOUR;
            dec.imm      = imm_j;
         end
         OPC_JALR: begin
            dec.rs1_read = 1'b1;
            dec.rd_write = 1'b1;
            dec.src1_sel = SRC1_PC;
            dec.src2_sel = SRC2_FOUR;
            dec.imm      = imm_i;
            illegal      = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.rs1_read = 1'b1;
            dec.rs2_read = 1'b1;
            dec.alu_op   = ALU_SUB;
            dec.imm      = imm_b;
            illegal      = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            dec.rs1_read = 1'b1;
            dec.rd_write = 1'b1;
            dec.src2_sel = SRC2_IMM;
            dec.imm      = imm_i;
            illegal      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec.rs1_read = 1'b1;
            dec.rs2_read = 1'b1;
            dec.src2_sel = SRC2_IMM;
            dec.imm      = imm_s;
            illegal      = (f3 > 3'b010);
         end
         default: illegal = 1'b1;
      endcase
      // An illegal bundle keeps only pc and register addresses; everything else is neutral.
      if (illegal) begin
         dec.rs1_read = 1'b0;
         dec.rs2_read = 1'b0;
         dec.rd_write = 1'b0;
         dec.imm      = '0;
         dec.alu_op   = ALU_ADD;
         dec.src1_sel = SRC1_RS1;
         dec.src2_sel = SRC2_RS2;
         dec.illegal  = 1'b1;
      end
      if (dec.rd_addr == 5'd0) dec.rd_write = 1'b0;
   end

   assign bus.in_ready = !bus.flush && (state_q == ST_RUN) && (!valid_q || bus.out_ready);
   assign xfer         = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the bundle registers are reset too, because every output must read 0 out of reset.
      if (rst) begin
         state_q  <= ST_RUN;
         valid_q  <= 1'b0;
         pc_q     <= '0;
         bundle_q <= '0;
      end else if (bus.flush) begin
         state_q <= ST_RUN;
         valid_q <= 1'b0;
      end else if (xfer) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         valid_q  <= 1'b1;
         pc_q     <= bus.in_pc;
         bundle_q <= dec;
         if (dec.illegal) state_q <= ST_TRAP;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_rs1_addr = bundle_q.rs1_addr;
   assign bus.out_rs2_addr = bundle_q.rs2_addr;
   assign bus.out_rd_addr  = bundle_q.rd_addr;
   assign bus.out_rs1_read = bundle_q.rs1_read;
   assign bus.out_rs2_read = bundle_q.rs2_read;
   assign bus.out_rd_write = bundle_q.rd_write;
   assign bus.out_imm      = bundle_q.imm;
   assign bus.out_alu_op   = bundle_q.alu_op;
   assign bus.out_src1_sel = bundle_q.src1_sel;
   assign bus.out_src2_sel = bundle_q.src2_sel;
   assign bus.out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: two instances (ENABLE_M=0 and 1) share one
// stimulus stream and are each compared against a behavioural decode/handshake model.
module tb_decode_stage;

   typedef logic [91:0] bund_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) if0 ();
   decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) if1 ();

   decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(1'b0)) dut_m0 (.clk(clk), .rst(rst), .bus(if0));
   decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(1'b1)) dut_m1 (.clk(clk), .rst(rst), .bus(if1));

   assign if1.flush     = if0.flush;
   assign if1.in_valid  = if0.in_valid;
   assign if1.in_instr  = if0.in_instr;
   assign if1.in_pc     = if0.in_pc;
   assign if1.out_ready = if0.out_ready;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model state per instance: bundle valid, bundle contents, trap flag.
   bit    mv[2];
   bund_t mb[2];
   bit    mtrap[2];

   function automatic bund_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit m_en);
      int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      logic [6:0] op = w[6:0];
      logic [2:0] f3 = w[14:12];
      logic [6:0] f7 = w[31:25];
      int imm = 0, alu = 0, s1 = 0, s2 = 0;
      bit r1 = 0, r2 = 0, wr = 0, ill = 0;
      case (op)
         7'h13: begin
            r1 = 1; wr = 1; s2 = 1; imm = $signed(w) >>> 20; alu = alu_tab[f3];
            if (f3 == 5 && f7 == 7'h20) alu = 7;
            ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
         end
         7'h33: begin
            r1 = 1; r2 = 1; wr = 1;
            if (f7 == 0) alu = alu_tab[f3];
            else if (f7 == 7'h20 && f3 == 0) alu = 1;
            else if (f7 == 7'h20 && f3 == 5) alu = 7;
            else if (f7 == 7'h01 && m_en) alu = 12 + int'(f3);
            else ill = 1;
         end
         7'h37: begin wr = 1; s1 = 2; s2 = 1; alu = 10; imm = int'(w & 32'hFFFFF000); end
         7'h17: begin wr = 1; s1 = 1; s2 = 1; imm = int'(w & 32'hFFFFF000); end
         7'h6F: begin
            wr = 1; s1 = 1; s2 = 2;
            imm = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         end
         7'h67: begin r1 = 1; wr = 1; s1 = 1; s2 = 2; imm = $signed(w) >>> 20; ill = (f3 != 0); end
         7'h63: begin
            r1 = 1; r2 = 1; alu = 1;
            imm = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            ill = (f3 == 2 || f3 == 3);
         end
         7'h03: begin r1 = 1; wr = 1; s2 = 1; imm = $signed(w) >>> 20; ill = (f3 inside {3, 6, 7}); end
         7'h23: begin
            r1 = 1; r2 = 1; s2 = 1; imm = int'($signed({w[31:25], w[11:7]}));
            ill = (f3 > 2);
         end
         default: ill = 1;
      endcase
      if (ill) begin
         r1 = 0; r2 = 0; wr = 0; imm = 0; alu = 0; s1 = 0; s2 = 0;
      end
      if (w[11:7] == 0) wr = 0;
      return {pc, w[19:15], w[24:20], w[11:7], r1, r2, wr, 32'(imm), 5'(alu), 2'(s1), 2'(s2), ill};
   endfunction

   function automatic bund_t dut_bundle(input int d);
      if (d == 0)
         return {if0.out_pc, if0.out_rs1_addr, if0.out_rs2_addr, if0.out_rd_addr, if0.out_rs1_read,
                 if0.out_rs2_read, if0.out_rd_write, if0.out_imm, if0.out_alu_op, if0.out_src1_sel,
                 if0.out_src2_sel, if0.out_illegal};
      return {if1.out_pc, if1.out_rs1_addr, if1.out_rs2_addr, if1.out_rd_addr, if1.out_rs1_read,
              if1.out_rs2_read, if1.out_rd_write, if1.out_imm, if1.out_alu_op, if1.out_src1_sel,
              if1.out_src2_sel, if1.out_illegal};
   endfunction

   function automatic logic dut_valid(input int d);
      return (d == 0) ? if0.out_valid : if1.out_valid;
   endfunction

   function automatic logic dut_ready(input int d);
      return (d == 0) ? if0.in_ready : if1.in_ready;
   endfunction

   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      if0.in_valid  = v;
      if0.in_instr  = w;
      if0.in_pc     = pc;
      if0.out_ready = ordy;
      if0.flush     = fl;
   endtask

   // Called at a falling edge with inputs already driven; advances one clock.
   task automatic cycle(input string tag);
      bit    rdy[2];
      bit    nv[2];
      bit    nt[2];
      bund_t nb[2];
      #1;
      for (int d = 0; d < 2; d++) begin
         rdy[d] = !if0.flush && !mtrap[d] && (!mv[d] || if0.out_ready);
         check($sformatf("%s/in_ready%0d", tag, d), dut_ready(d), rdy[d]);
         nb[d] = mb[d];
         nt[d] = mtrap[d];
         if (if0.flush) begin
            nv[d] = 0;
            nt[d] = 0;
         end else if (if0.in_valid && rdy[d]) begin
            nv[d] = 1;
            nb[d] = ref_decode(if0.in_instr, if0.in_pc, d == 1);
            nt[d] = nb[d][0];
         end else begin
            nv[d] = mv[d] && !if0.out_ready;
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         mv[d]    = nv[d];
         mb[d]    = nb[d];
         mtrap[d] = nt[d];
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s/out_valid%0d", tag, d), dut_valid(d), mv[d]);
         if (mv[d]) check($sformatf("%s/bundle%0d", tag, d), dut_bundle(d), mb[d]);
      end
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] tab[12] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67,
                              7'h63, 7'h03, 7'h23, 7'h73, 7'h0F, 7'h33};
      logic [6:0] f7tab[4] = '{7'h00, 7'h20, 7'h01, 7'h5A};
      logic [31:0] w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = tab[$urandom_range(0, 11)];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
         w[31:25] = f7tab[$urandom_range(0, 3)];
      return w;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         mv[d] = 0; mb[d] = '0; mtrap[d] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      check("reset/out_valid", if0.out_valid, 1'b0);
      check("reset/bundle", dut_bundle(0), 92'h0);
      rst = 1'b0;
      #1 check("reset/in_ready", if0.in_ready, 1'b1);

      drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
      cycle("addi");
      check("addi/out_valid", if0.out_valid, 1'b1);
      check("addi/alu_op", if0.out_alu_op, 5'd0);
      check("addi/imm", if0.out_imm, 32'd5);
      check("addi/rd_addr", if0.out_rd_addr, 5'd1);
      check("addi/rd_write", if0.out_rd_write, 1'b1);
      check("addi/rs1_read", if0.out_rs1_read, 1'b1);
      check("addi/src2_sel", if0.out_src2_sel, 2'd1);

      drive(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
      cycle("sub");
      check("sub/alu_op", if0.out_alu_op, 5'd1);
      drive(1'b1, 32'h40335293, 32'h108, 1'b1, 1'b0);
      cycle("srai");
      check("srai/out_valid", if0.out_valid, 1'b1);
      check("srai/alu_op", if0.out_alu_op, 5'd7);
      check("srai/imm", if0.out_imm, 32'h403);

      drive(1'b1, 32'h00A00113, 32'h10C, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle("hold");
         check("hold/in_ready", if0.in_ready, 1'b0);
         check("hold/imm", if0.out_imm, 32'h403);
      end
      drive(1'b1, 32'h00A00113, 32'h10C, 1'b1, 1'b0);
      cycle("release");
      check("release/imm", if0.out_imm, 32'd10);
      check("release/pc", if0.out_pc, 32'h10C);

      drive(1'b1, 32'h023100B3, 32'h110, 1'b1, 1'b0);
      cycle("mul");
      check("mul/m1_alu_op", if1.out_alu_op, 5'd12);
      check("mul/m1_illegal", if1.out_illegal, 1'b0);
      check("mul/m0_illegal", if0.out_illegal, 1'b1);
      drive(1'b1, 32'h00500093, 32'h114, 1'b1, 1'b0);
      cycle("trap");
      cycle("trap");
      check("trap/in_ready", if0.in_ready, 1'b0);
      check("trap/out_valid", if0.out_valid, 1'b0);
      drive(1'b1, 32'h00500093, 32'h114, 1'b1, 1'b1);
      cycle("flush");
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1 check("flush/in_ready", if0.in_ready, 1'b1);

      drive(1'b1, 32'h123450B7, 32'h200, 1'b1, 1'b0);
      cycle("lui");
      check("lui/imm", if0.out_imm, 32'h12345000);
      check("lui/alu_op", if0.out_alu_op, 5'd10);
      check("lui/src1_sel", if0.out_src1_sel, 2'd2);
      drive(1'b1, 32'hFFFFFFFF, 32'h204, 1'b1, 1'b0);
      cycle("ones");
      check("ones/illegal", if0.out_illegal, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      cycle("flush2");

      drive(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
      cycle("pre_rst");
      #2 rst = 1'b1;
      #1;
      check("async_rst/out_valid0", if0.out_valid, 1'b0);
      check("async_rst/out_valid1", if1.out_valid, 1'b0);
      check("async_rst/bundle", dut_bundle(0), 92'h0);
      for (int d = 0; d < 2; d++) begin
         mv[d] = 0; mb[d] = '0; mtrap[d] = 0;
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
         cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction decode stage with a valid/ready handshake on both sides. It replaces purely combinational decoding with one pipeline register between fetch and execute. It adds full sign-extended immediates, register addresses, an optional M-extension, illegal-instruction detection with a trap-hold state, and a pipeline flush.

Parameters:
XLEN, 32, datapath and immediate width (32 only is legal; any other value is an elaboration error).
PC_WIDTH, 32, width of the pc passthrough.
ENABLE_M, 0, 1 = decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = these encodings are illegal.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  discard held output and leave TRAP; has priority over all else
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  PC_WIDTH  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  PC_WIDTH  registered pc
out_rs1_addr / out_rs2_addr / out_rd_addr  out  5 each  instr[19:15] / [24:20] / [11:7]
out_rs1_read / out_rs2_read  out  1 each  operand register used
out_rd_write  out  1  writes rd (forced 0 when rd = x0)
out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J per opcode; 0 for R-type)
out_alu_op  out  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 12-15 MUL/MULH/MULHSU/MULHU, 16-19 DIV/DIVU/REM/REMU
out_src1_sel  out  2  0 rs1, 1 pc, 2 zero
out_src2_sel  out  2  0 rs2, 1 imm, 2 constant 4
out_illegal  out  1  bundle is an illegal instruction

Behaviour:
- Reset (async, rst=1): state RUN, out_valid=0, every other output 0, in_ready=1 once rst is deasserted.
- States: RUN, TRAP.
- RUN: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready; the decoded bundle is registered on that edge, so latency is 1 cycle. While out_valid && !out_ready, all outputs are held stable.
- On out_valid && out_ready with no new transfer, out_valid goes to 0 next cycle. Simultaneous accept and new transfer gives back-to-back bundles at full throughput.
- Illegal on transfer: out_illegal=1, rs*_read=0, rd_write=0, alu_op=ADD, and the state goes to TRAP.
- TRAP: in_ready=0. The illegal bundle is presented until accepted, then out_valid=0. The block stays in TRAP until flush.
- Flush: on the next edge, out_valid=0 and state goes to RUN. A same-cycle in_valid is dropped (in_ready is 0 while flush=1).
- Decode rules:
  - OP-IMM: src1=rs1, src2=imm.
  - OP: src2=rs2, rs2_read=1.
  - LUI: PASSB with imm, src1=zero.
  - AUIPC: ADD, src1=pc, src2=imm.
  - JAL: ADD, src1=pc, src2=4, rd_write=1.
  - JALR: same as JAL, plus rs1_read=1.
  - BRANCH: SUB, both reads, rd_write=0, B-imm.
  - LOAD/STORE: ADD, rs1+imm; STORE also sets rs2_read=1 and rd_write=0.
- Illegal when:
  - instr[1:0] != 2'b11, or the opcode is not listed above;
  - OP funct7 is not 0000000 or 0100000 (0100000 only with f3 = 000 or 101), or is 0000001 with ENABLE_M=0;
  - SLLI funct7 != 0, or SRLI/SRAI funct7 is not 0000000 or 0100000;
  - BRANCH f3 is 010 or 011, LOAD f3 is 011, 110 or 111, STORE f3 > 010, or JALR f3 != 0.

Test Plan:
- Reset, then 0x00500093 (ADDI x1,x0,5) -> next cycle out_valid=1, alu_op=0, imm=5, rd_addr=1, rd_write=1, rs1_read=1, src2_sel=1.
- 0x402081B3 (SUB x3,x1,x2), then 0x40335293 (SRAI x5,x6,3) back-to-back with out_ready=1 -> two consecutive bundles: alu_op 1, then alu_op 7 with imm=0x403.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the bundle is held unchanged; release -> next instruction follows 1 cycle later.
- 0x023100B3 (MUL x1,x2,x3) with ENABLE_M=1 -> alu_op=12, not illegal; with ENABLE_M=0 -> out_illegal=1, state TRAP, in_ready=0 until flush.
- 0x123450B7 (LUI x1,0x12345) -> imm=0x12345000, alu_op=10, src1_sel=2. 0xFFFFFFFF -> out_illegal=1.
- Assert rst mid-stream with out_valid=1 -> out_valid drops immediately without waiting for clk. Assert flush while in TRAP -> next cycle RUN, in_ready=1.
